// File: rtl/controller_emulator.sv
// controller_emulator
//
// Emulates a console game-pad: the console raises latch to capture the
// current button state, then clocks the bits out one per pulse rising edge,
// most significant button first.  Output data is active-low (0 = pressed).
// After the last real bit the shift register is full of 1 fill bits, so the
// pad keeps reporting "pressed" until the next latch, as real hardware does.
//
// Build option:
//   CONTROLLER_EMULATOR_SNES_16BIT_EN  defined   -> 16-bit frame from buttons_i[15:0]
//                                      undefined -> 8-bit frame from buttons_i[15:8]
//
// Parameters:
//   SYNC_STAGES   flip-flop stages on each asynchronous console input (2..4)
//
// Ports:
//   clk           system clock, all state changes on its rising edge
//   rst           synchronous, active-high reset
//   buttons_i     button states, 1 = pressed, bit 15 sent first
//   latch_i       console latch (asynchronous to clk)
//   pulse_i       console data clock (asynchronous to clk), rising edge = next bit
//   serial_no     registered serial data to console, active-low
//   busy_o        high while a frame is being shifted out
//   frame_done_o  one-cycle pulse when the last frame bit has been consumed
//   bit_count_o   pulse edges consumed in the current frame

module controller_emulator #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] buttons_i,
   input  logic        latch_i,
   input  logic        pulse_i,
   output logic        serial_no,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic [4:0]  bit_count_o
);

`ifdef CONTROLLER_EMULATOR_SNES_16BIT_EN
   localparam int N = 16;
`else
   localparam int N = 8;
`endif
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

   state_t          state_reg, state_next;
   logic [N-1:0]    sreg_reg, sreg_next;
   logic [CW-1:0]   count_reg, count_next;
   logic            serial_no_reg;
   logic            frame_done_reg, frame_done_next;
   logic [N-1:0]    load_value;

   // ------------------------------------------------------------------
   // Active button bits
   // ------------------------------------------------------------------
`ifdef CONTROLLER_EMULATOR_SNES_16BIT_EN
   assign load_value = buttons_i;
`else
   logic unused_buttons;
   assign load_value     = buttons_i[15:8];
   assign unused_buttons = ^buttons_i[7:0];
`endif

   // ------------------------------------------------------------------
   // Input synchronizers plus one extra registered copy for edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] latch_sync_reg, pulse_sync_reg;
   logic                   latch_d_reg, pulse_d_reg;
   logic                   latch_s, pulse_s;
   logic                   latch_rise, latch_fall, pulse_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         latch_sync_reg <= '0;
         pulse_sync_reg <= '0;
         latch_d_reg    <= 1'b0;
         pulse_d_reg    <= 1'b0;
      end else begin
         latch_sync_reg <= {latch_sync_reg[SYNC_STAGES-2:0], latch_i};
         pulse_sync_reg <= {pulse_sync_reg[SYNC_STAGES-2:0], pulse_i};
         latch_d_reg    <= latch_s;
         pulse_d_reg    <= pulse_s;
      end
   end

   assign latch_s    = latch_sync_reg[SYNC_STAGES-1];
   assign pulse_s    = pulse_sync_reg[SYNC_STAGES-1];
   assign latch_rise = latch_s & ~latch_d_reg;
   assign latch_fall = ~latch_s & latch_d_reg;
   assign pulse_rise = pulse_s & ~pulse_d_reg;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state (a latch rising edge outranks any pulse edge)
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (latch_rise) state_next = LATCH;
         LATCH: if (latch_fall) state_next = SHIFT;
         SHIFT: begin
            if (latch_rise)
               state_next = LATCH;
            else if (pulse_rise && count_reg == CW'(N - 1))
               state_next = DONE;
         end
         DONE:  if (latch_rise) state_next = LATCH;
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      busy_o = (state_reg == SHIFT);
   end

   // ------------------------------------------------------------------
   // Shift register and bit counter
   // ------------------------------------------------------------------
   always_comb begin
      sreg_next       = sreg_reg;
      count_next      = count_reg;
      frame_done_next = 1'b0;
      if (state_next == LATCH) begin
         // Entering or staying in LATCH implies latch_s is high: keep
         // sampling the buttons so the frame reflects the latest state.
         sreg_next  = load_value;
         count_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               sreg_next  = '0;
               count_next = '0;
            end
            SHIFT: begin
               if (pulse_rise) begin
                  sreg_next  = {sreg_reg[N-2:0], 1'b1};
                  count_next = count_reg + CW'(1);
                  frame_done_next = (state_next == DONE);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_reg       <= '0;
         count_reg      <= '0;
         serial_no_reg  <= 1'b1;
         frame_done_reg <= 1'b0;
      end else begin
         sreg_reg       <= sreg_next;
         count_reg      <= count_next;
         // Registered copy of the current head bit; while latch is still
         // high this already presents the first button on the pin.
         serial_no_reg  <= ~sreg_reg[N-1];
         frame_done_reg <= frame_done_next;
      end
   end

   assign serial_no    = serial_no_reg;
   assign frame_done_o = frame_done_reg;
   assign bit_count_o  = 5'(count_reg);

endmodule

// File: tb/tb_controller_emulator.sv
// Testbench for controller_emulator.
// A frame-level model (button word + number of bits consumed) predicts every
// output on every clock; directed sequences add literal expectations.

module tb_controller_emulator;

   localparam int S = 2;
`ifdef CONTROLLER_EMULATOR_SNES_16BIT_EN
   localparam int N = 16;
`else
   localparam int N = 8;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] buttons = 16'h0000;
   logic        latch = 1'b0;
   logic        pulse = 1'b0;
   logic        serial_no;
   logic        busy;
   logic        frame_done;
   logic [4:0]  bit_count;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   always #5 clk = ~clk;

   controller_emulator #(.SYNC_STAGES(S)) dut (
      .clk          (clk),
      .rst          (rst),
      .buttons_i    (buttons),
      .latch_i      (latch),
      .pulse_i      (pulse),
      .serial_no    (serial_no),
      .busy_o       (busy),
      .frame_done_o (frame_done),
      .bit_count_o  (bit_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Frame-level model
   // ------------------------------------------------------------------
   typedef enum {M_IDLE, M_LATCHED, M_SHIFTING, M_DONE} mode_t;
   mode_t       mode = M_IDLE;
   logic [15:0] frame = '0;
   int          consumed = 0;
   logic        lh [0:7];
   logic        ph [0:7];
   logic        exp_serial = 1'b1;
   logic        exp_done = 1'b0;

   initial begin
      logic l_now, l_old, p_now, p_old, cb;
      logic [15:0] act;
      for (int j = 0; j < 8; j++) begin lh[j] = 1'b0; ph[j] = 1'b0; end
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            for (int j = 0; j < 8; j++) begin lh[j] = 1'b0; ph[j] = 1'b0; end
            mode = M_IDLE; frame = '0; consumed = 0;
            exp_serial = 1'b1; exp_done = 1'b0;
         end else begin
            for (int j = 7; j > 0; j--) begin lh[j] = lh[j-1]; ph[j] = ph[j-1]; end
            lh[0] = latch; ph[0] = pulse;
            // level seen by the pad logic this edge, and the one before
            l_now = lh[S]; l_old = lh[S+1];
            p_now = ph[S]; p_old = ph[S+1];
            act = (N == 16) ? buttons : {8'h00, buttons[15:8]};
            // pin shows the bit that was at the head before this edge
            cb = (consumed < N) ? frame[N-1-consumed] : 1'b1;
            exp_serial = ~cb;
            exp_done = 1'b0;
            if (l_now && !l_old) begin
               mode = M_LATCHED; consumed = 0; frame = act;
            end else begin
               case (mode)
                  M_LATCHED: begin
                     if (!l_now) mode = M_SHIFTING;
                     else frame = act;
                  end
                  M_SHIFTING: begin
                     if (p_now && !p_old) begin
                        consumed++;
                        if (consumed == N) begin mode = M_DONE; exp_done = 1'b1; end
                     end
                  end
                  default: ;
               endcase
            end
         end
         check("serial_no", serial_no, exp_serial);
         check("busy_o", busy, mode == M_SHIFTING);
         check("frame_done_o", frame_done, exp_done);
         check("bit_count_o", bit_count, consumed);
         if (frame_done === 1'b1) done_seen++;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge)
   // ------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_pulse();
      @(negedge clk);
      pulse = 1'b1;
      tick(8);
      pulse = 1'b0;
      tick(8);
   endtask

   task automatic do_latch();
      @(negedge clk);
      latch = 1'b1;
      tick(8);
      latch = 1'b0;
      tick(8);
   endtask

   initial begin
      int d0;
      logic [7:0]  ser8;
      logic [15:0] ser16;

      rst = 1'b1;
      tick(4);
      check("reset serial_no", serial_no, 1'b1);
      check("reset busy_o", busy, 1'b0);
      check("reset frame_done_o", frame_done, 1'b0);
      check("reset bit_count_o", bit_count, 5'd0);
      rst = 1'b0;
      tick(2);

`ifdef CONTROLLER_EMULATOR_SNES_16BIT_EN
      // 16-bit frame 8001: pressed, 14 released, pressed
      buttons = 16'h8001;
      ser16 = 16'b0111_1111_1111_1110;
      d0 = done_seen;
      do_latch();
      for (int i = 0; i < 16; i++) begin
         check("16b serial before pulse", serial_no, ser16[15-i]);
         do_pulse();
      end
      check("16b frame_done count", done_seen - d0, 1);
      check("16b bit_count", bit_count, 5'd16);
      check("16b fill serial", serial_no, 1'b0);
`else
      // Frame A5 with junk in the ignored low byte
      buttons = 16'hA53C;
      ser8 = 8'b0101_1010;
      d0 = done_seen;
      do_latch();
      check("A5 busy after latch", busy, 1'b1);
      for (int i = 0; i < 8; i++) begin
         check("A5 serial before pulse", serial_no, ser8[7-i]);
         if (i == 7) check("A5 no early done", done_seen - d0, 0);
         do_pulse();
      end
      check("A5 frame_done count", done_seen - d0, 1);
      check("A5 bit_count", bit_count, 5'd8);
      check("A5 busy in done", busy, 1'b0);

      // Extra pulses after the frame: fill reads pressed, count saturates
      repeat (3) do_pulse();
      check("extra serial", serial_no, 1'b0);
      check("extra bit_count", bit_count, 5'd8);
      check("extra no done", done_seen - d0, 1);

      // Pulses while latch is held are ignored
      buttons = 16'h8100;
      @(negedge clk);
      latch = 1'b1;
      tick(8);
      repeat (4) do_pulse();
      check("latched bit_count", bit_count, 5'd0);
      check("latched busy", busy, 1'b0);
      latch = 1'b0;
      tick(8);
      check("81 first serial", serial_no, 1'b0);
      check("81 busy", busy, 1'b1);
      do_pulse();
      check("81 second serial", serial_no, 1'b1);
      check("81 bit_count", bit_count, 5'd1);

      // Relatch after 3 bits abandons the frame
      buttons = 16'h5A00;
      do_latch();
      repeat (3) do_pulse();
      check("partial bit_count", bit_count, 5'd3);
      d0 = done_seen;
      buttons = 16'hC300;
      @(negedge clk);
      latch = 1'b1;
      tick(8);
      check("relatch bit_count", bit_count, 5'd0);
      check("relatch busy", busy, 1'b0);
      check("relatch no done", done_seen - d0, 0);
      latch = 1'b0;
      tick(8);
      ser8 = 8'b0011_1100;
      for (int i = 0; i < 8; i++) begin
         check("C3 serial before pulse", serial_no, ser8[7-i]);
         do_pulse();
      end
      check("C3 frame_done count", done_seen - d0, 1);

      // Latch and pulse rising together: latch wins
      buttons = 16'hF000;
      do_latch();
      repeat (2) do_pulse();
      check("pre-collide bit_count", bit_count, 5'd2);
      buttons = 16'h0F00;
      @(negedge clk);
      latch = 1'b1;
      pulse = 1'b1;
      tick(8);
      check("collide bit_count", bit_count, 5'd0);
      latch = 1'b0;
      pulse = 1'b0;
      tick(8);
      check("collide busy", busy, 1'b1);
      check("collide bit_count after", bit_count, 5'd0);
      check("collide serial", serial_no, 1'b1);

      // Reset mid-frame
      buttons = 16'hFF00;
      do_latch();
      repeat (5) do_pulse();
      check("pre-reset bit_count", bit_count, 5'd5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid reset serial", serial_no, 1'b1);
      check("mid reset busy", busy, 1'b0);
      check("mid reset bit_count", bit_count, 5'd0);
      rst = 1'b0;
      repeat (3) do_pulse();
      check("post reset bit_count", bit_count, 5'd0);
      check("post reset serial", serial_no, 1'b1);
      check("post reset busy", busy, 1'b0);
      buttons = 16'h8000;
      do_latch();
      check("fresh frame serial", serial_no, 1'b0);
      check("fresh frame busy", busy, 1'b1);
`endif
      tick(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
